// File: rtl/prbs31_checker_32b.sv
// Receive-side PRBS31 (x^31 + x^28 + 1) checker, 32 bits per clock: self-syncs, then counts errored words/bits and lock losses.
// Optional: define PRBS_CHK_BITERR_EN to build the errored-bit popcount and err_bit_cnt accumulator.
module prbs31_checker_32b #(
  parameter int LOCK_CNT   = 64,
  parameter int UNLOCK_CNT = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_valid,
  input  logic [31:0]      rx_data,
  input  logic             clear,
  output logic             locked,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_word_cnt,
  output logic [CNT_W-1:0] err_bit_cnt,
  output logic [15:0]      lock_loss_cnt
);

  localparam logic SEARCH = 1'b0;
  localparam logic LOCKED = 1'b1;
  localparam int   MW     = $clog2(LOCK_CNT + 1);
  localparam int   BW     = $clog2(UNLOCK_CNT + 1);

  function automatic logic [31:0] prbs_next(input logic [31:0] p);
    logic [31:0] n;
    n[31:4] = p[30:3] ^ p[27:0];
    n[3:0]  = {p[2:0], n[31]} ^ n[31:28];
    return n;
  endfunction

  logic          state;
  logic [31:0]   rx_prev;
  logic          prev_vld;
  logic [MW-1:0] match_cnt;
  logic [BW-1:0] bad_cnt;
  logic [31:0]   exp_w;
  logic          word_pend;
  logic          loss_pend;

  logic [31:0] diff;
  logic        rx_match;

  assign diff     = rx_data ^ exp_w;
  assign rx_match = (rx_data == prbs_next(rx_prev)) && (rx_data != 32'h0);
  assign locked   = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= SEARCH;
      rx_prev   <= '0;
      prev_vld  <= 1'b0;
      match_cnt <= '0;
      bad_cnt   <= '0;
      exp_w     <= '0;
      err_flag  <= 1'b0;
      word_pend <= 1'b0;
      loss_pend <= 1'b0;
    end else begin
      err_flag  <= 1'b0;
      word_pend <= 1'b0;
      loss_pend <= 1'b0;
      if (rx_valid) begin
        if (state == SEARCH) begin
          rx_prev  <= rx_data;
          prev_vld <= 1'b1;
          if (!prev_vld || !rx_match) begin
            match_cnt <= '0;
          end else if (match_cnt == MW'(LOCK_CNT - 1)) begin
            state     <= LOCKED;
            exp_w     <= prbs_next(rx_data);
            bad_cnt   <= '0;
            match_cnt <= '0;
          end else begin
            match_cnt <= match_cnt + 1'b1;
          end
        end else begin
          // Reference free-runs so a single flipped bit is charged once.
          exp_w <= prbs_next(exp_w);
          if (diff != 32'h0) begin
            err_flag  <= 1'b1;
            word_pend <= 1'b1;
            if (bad_cnt == BW'(UNLOCK_CNT - 1)) begin
              state     <= SEARCH;
              loss_pend <= 1'b1;
              rx_prev   <= rx_data;
              prev_vld  <= 1'b1;
              match_cnt <= '0;
              bad_cnt   <= '0;
            end else begin
              bad_cnt <= bad_cnt + 1'b1;
            end
          end else begin
            bad_cnt <= '0;
          end
        end
      end
      // A clear drops events still in flight to the counters.
      if (clear) begin
        word_pend <= 1'b0;
        loss_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      err_word_cnt  <= '0;
      lock_loss_cnt <= '0;
    end else begin
      if (word_pend && (err_word_cnt != '1))  err_word_cnt  <= err_word_cnt + 1'b1;
      if (loss_pend && (lock_loss_cnt != '1)) lock_loss_cnt <= lock_loss_cnt + 1'b1;
    end
  end

`ifdef PRBS_CHK_BITERR_EN
  localparam int SW = ((CNT_W > 6) ? CNT_W : 6) + 1;
  localparam logic [SW-1:0] CNT_MAX = {{(SW-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  logic [31:0]   diff_q;
  logic [5:0]    pop;
  logic [SW-1:0] bit_sum;

  always_ff @(posedge clk) begin
    if (!reset) diff_q <= '0;
    else if (rx_valid && (state == LOCKED) && !clear) diff_q <= diff;
    else diff_q <= '0;
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < 32; i++) pop = pop + 6'(diff_q[i]);
  end

  assign bit_sum = SW'(err_bit_cnt) + SW'(pop);

  always_ff @(posedge clk) begin
    if (!reset || clear)        err_bit_cnt <= '0;
    else if (bit_sum > CNT_MAX) err_bit_cnt <= '1;
    else                        err_bit_cnt <= bit_sum[CNT_W-1:0];
  end
`else
  assign err_bit_cnt = '0;
`endif

endmodule

// File: doc/prbs31_checker_32b.md
# prbs31_checker_32b

Receive-side PRBS31 checker for the GBCR link SEU/BER test path. Consumes the 32-bit-per-clock PRBS31 stream (x^31 + x^28 + 1, same 32-bit parallel recurrence as the transmit-side generator) after it has crossed the link under test. Self-synchronises to the stream, then free-runs a local reference and counts errored words, errored bits and lock losses for readout by the test controller.

## Interface
Parameters:
- LOCK_CNT, 64, consecutive matching words required in SEARCH before entering LOCKED
- UNLOCK_CNT, 4, consecutive errored words in LOCKED that force return to SEARCH
- CNT_W, 32, width of err_word_cnt and err_bit_cnt

Ports:
- clk  in  1  single clock; all logic on its rising edge
- reset  in  1  synchronous, active-low; sampled on clk
- rx_valid  in  1  rx_data valid this cycle; when low nothing advances
- rx_data  in  32  received PRBS word
- clear  in  1  synchronous clear of all three counters; lock state unaffected
- locked  out  1  high in LOCKED
- err_flag  out  1  one-cycle pulse per errored word in LOCKED
- err_word_cnt  out  CNT_W  errored words seen in LOCKED, saturating
- err_bit_cnt  out  CNT_W  errored bits seen in LOCKED, saturating
- lock_loss_cnt  out  16  LOCKED→SEARCH transitions, saturating

## Operation
- f(p): n[31:4] = p[30:3] ^ p[27:0]; n[3:0] = {p[2:0], n[31]} ^ n[31:28]. f(32'hFFFFFFFF) = 32'h0000000E.
- States: SEARCH, LOCKED. Reset → SEARCH, all outputs 0, match_cnt = bad_cnt = 0, rx_prev invalid.
- SEARCH, per valid word:
  - rx_prev invalid: load rx_prev, mark valid, match_cnt = 0.
  - else match ⇔ rx_data == f(rx_prev) and rx_data != 0 (all-zero stuck link must never lock). Match: match_cnt++; mismatch: match_cnt = 0. rx_prev <= rx_data.
  - match with match_cnt == LOCK_CNT−1 → LOCKED, exp <= f(rx_data), bad_cnt = 0.
  - No counters or err_flag activity in SEARCH.
- LOCKED, per valid word:
  - diff = rx_data ^ exp; exp <= f(exp) (independent of rx_data, so one flipped bit is counted once).
  - diff != 0: err_flag pulse, err_word_cnt += 1, err_bit_cnt += popcount(diff) (0..32), bad_cnt++.
  - diff == 0: bad_cnt = 0.
  - bad_cnt reaching UNLOCK_CNT → SEARCH, lock_loss_cnt += 1, rx_prev <= rx_data (valid), match_cnt = 0. The unlocking word is still counted.
- Arithmetic: all counters saturate at all-ones; err_bit_cnt clamps if sum exceeds max.
- clear concurrent with an update: clear wins, counter = 0, event dropped.
- reset low mid-operation: next edge returns to reset state regardless of rx_valid/clear.

## Timing
- Word accepted at edge k (rx_valid high): state, exp, rx_prev, match_cnt, bad_cnt update at k; err_flag high for the cycle after k.
- err_word_cnt, lock_loss_cnt update at edge k+1; err_bit_cnt at edge k+1 (registered diff at k, popcount/add at k+1).
- locked rises on edge accepting word LOCK_CNT+1 of a clean stream (65 with defaults); falls on edge accepting the UNLOCK_CNT-th consecutive errored word.
- rx_valid low cycles: no advance, err_flag low, match/bad runs preserved.
- Throughput: one word per clock, no backpressure.

## Configuration
- PRBS_CHK_BITERR_EN defined: diff register, 32-bit popcount and err_bit_cnt accumulator built as above.
- Undefined: no popcount logic; err_bit_cnt tied to 0; err_word_cnt timing unchanged.

## Test plan
- Reset, clean stream seeded 32'hFFFFFFFF (second word 32'h0000000E), rx_valid = 1 → locked high after word 65; after 10000 words all counters 0, err_flag never high.
- Locked, flip rx_data[0] of one word → one err_flag pulse, err_word_cnt = 1, err_bit_cnt = 1, locked stays 1, next word clean.
- Locked, XOR one word with 32'h8000_0F00 (5 bits) → err_word_cnt +1, err_bit_cnt +5 (0 with macro undefined).
- 200 words of 32'h00000000 after reset → locked never asserts, counters 0.
- Locked, 4 consecutive words inverted → locked drops on 4th, lock_loss_cnt = 1, err_word_cnt = 4, err_bit_cnt = 128; relocks after 65 clean words.
- CNT_W = 4: 20 single-bit errored words with gaps → err_word_cnt = 15 saturated; clear asserted coincident with an errored word → counters read 0 next cycle.
